// File: rtl/bscan_user_dr_if.sv
// Signal bundle between the BSCANE2 user port / system consumer and bscan_user_dr.
// The master side drives the TAP strobes and upd_ready; the slave is the data register.
interface bscan_user_dr_if #(
  parameter int DR_WIDTH = 32
);
  logic                sel;
  logic                capture;
  logic                shift;
  logic                update;
  logic                tdi;
  logic                tdo;
  logic [DR_WIDTH-1:0] cap_data;
  logic [DR_WIDTH-1:0] upd_data;
  logic                upd_valid;
  logic                upd_ready;
  logic                overrun;
  logic                len_err;

  modport master (
    output sel, capture, shift, update, tdi, cap_data, upd_ready,
    input  tdo, upd_data, upd_valid, overrun, len_err
  );

  modport slave (
    input  sel, capture, shift, update, tdi, cap_data, upd_ready,
    output tdo, upd_data, upd_valid, overrun, len_err
  );
endinterface

// File: rtl/bscan_user_dr.sv
// TCK-domain capture/shift/update data register behind BSCANE2, with a valid/ready
// hand-off of each completed scan. Define BSCAN_DR_LENCHECK_EN to reject short/long scans.
module bscan_user_dr #(
  parameter int DR_WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  bscan_user_dr_if.slave    bus
);

  localparam int CW = $clog2(DR_WIDTH + 2);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DR_WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DR_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURED = 2'd1,
    SHIFTING = 2'd2
  } state_t;

  state_t              state_r;
  logic [DR_WIDTH-1:0] sr_r;
  logic [CW-1:0]       cnt_r;
  logic [DR_WIDTH-1:0] upd_data_r;
  logic                upd_valid_r;
  logic                overrun_r;
  logic                len_err_r;

  logic                do_cap_s;
  logic                scan_done_s;
  logic                len_ok_s;
  logic                accept_s;
  logic                store_s;
  logic                ovr_set_s;
  logic                len_set_s;
  logic [CW-1:0]       cnt_inc_s;
  logic                unused_cap_s;

  // Low two capture bits are replaced by the status flags.
  assign unused_cap_s = ^bus.cap_data[1:0];

  // Strobe decode with capture > shift > update priority, plus scan acceptance.
  always_comb begin
    do_cap_s    = bus.sel & bus.capture;
    scan_done_s = bus.sel & ~bus.capture & ~bus.shift & bus.update & (state_r == SHIFTING);
`ifdef BSCAN_DR_LENCHECK_EN
    len_ok_s    = (cnt_r == CNT_FULL);
`else
    len_ok_s    = (cnt_r != CNT_ZERO);
`endif
    accept_s    = scan_done_s & len_ok_s;
    store_s     = accept_s & (~upd_valid_r | bus.upd_ready);
    ovr_set_s   = accept_s & upd_valid_r & ~bus.upd_ready;
    len_set_s   = scan_done_s & ~len_ok_s;
    cnt_inc_s   = (cnt_r == CNT_SAT) ? CNT_SAT : (cnt_r + CW'(1));
  end

  // Scan FSM, shift register, hand-off register and sticky flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      sr_r        <= '0;
      cnt_r       <= CNT_ZERO;
      upd_data_r  <= '0;
      upd_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
      len_err_r   <= 1'b0;
    end else begin
      if (store_s) begin
        upd_data_r  <= sr_r;
        upd_valid_r <= 1'b1;
      end else if (upd_valid_r & bus.upd_ready) begin
        upd_valid_r <= 1'b0;
      end else begin
        upd_valid_r <= upd_valid_r;
      end

      // A set on the same edge as a read-to-clear capture wins.
      overrun_r <= (overrun_r & ~do_cap_s) | ovr_set_s;
      len_err_r <= (len_err_r & ~do_cap_s) | len_set_s;

      if (!bus.sel) begin
        state_r <= IDLE;
        cnt_r   <= CNT_ZERO;
      end else if (bus.capture) begin
        sr_r    <= {bus.cap_data[DR_WIDTH-1:2], len_err_r, overrun_r};
        cnt_r   <= CNT_ZERO;
        state_r <= CAPTURED;
      end else if (bus.shift) begin
        case (state_r)
          CAPTURED, SHIFTING: begin
            sr_r    <= {bus.tdi, sr_r[DR_WIDTH-1:1]};
            cnt_r   <= cnt_inc_s;
            state_r <= SHIFTING;
          end
          IDLE: begin
            state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end
        endcase
      end else if (bus.update) begin
        state_r <= IDLE;
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.tdo       = bus.sel ? sr_r[0] : 1'b0;
  assign bus.upd_data  = upd_data_r;
  assign bus.upd_valid = upd_valid_r;
  assign bus.overrun   = overrun_r;
  assign bus.len_err   = len_err_r;

endmodule

// File: doc/bscan_user_dr.md
# bscan_user_dr

User data register that sits directly downstream of the BSCANE2 primitive. It consumes the primitive's SEL/CAPTURE/SHIFT/UPDATE/TDI strobes and drives its TDO. It implements a DR_WIDTH-bit capture/shift/update register in the TCK domain. Each completed scan is handed to the system side through a valid/ready port, with sticky error status that the host reads back on the next capture.

## Interface
- DR_WIDTH, default 32: scan register length in bits; minimum 4.
- clock  input  1  TCK from BSCANE2; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces all state to reset values immediately.
- sel  input  1  BSCANE2 SEL; user instruction selected.
- capture  input  1  BSCANE2 CAPTURE (Capture-DR).
- shift  input  1  BSCANE2 SHIFT (Shift-DR).
- update  input  1  BSCANE2 UPDATE (Update-DR).
- tdi  input  1  BSCANE2 TDI.
- tdo  output  1  to BSCANE2 TDO.
- cap_data  input  DR_WIDTH  system value loaded at capture; bits [1:0] are ignored.
- upd_data  output  DR_WIDTH  last accepted scan word.
- upd_valid  output  1  upd_data is pending.
- upd_ready  input  1  consumer accepts upd_data.
- overrun  output  1  sticky: a scan completed while upd_valid was held and was not accepted.
- len_err  output  1  sticky: a scan ended with shift count not equal to DR_WIDTH. Driven 0 when BSCAN_DR_LENCHECK_EN is undefined.

## Operation
- Registers:
  - sr[DR_WIDTH-1:0]
  - cnt, width clog2(DR_WIDTH+2), saturating at DR_WIDTH+1
  - state ∈ {IDLE, CAPTURED, SHIFTING}
  - upd_data, upd_valid, overrun, len_err
- tdo = sel ? sr[0] : 0, combinational.
- sel low on any edge: state → IDLE and cnt → 0. sr, upd_*, and flags are held. A scan aborted by deselect never updates.
- sel & capture, any state:
  - sr ← {cap_data[DR_WIDTH-1:2], len_err, overrun}
  - overrun and len_err clear (read-to-clear)
  - cnt ← 0
  - state → CAPTURED
- sel & shift in CAPTURED or SHIFTING:
  - sr ← {tdi, sr[DR_WIDTH-1:1]}
  - cnt ← min(cnt+1, DR_WIDTH+1)
  - state → SHIFTING
  - shift in IDLE is ignored.
- sel & update:
  - In CAPTURED, or IDLE: no-op, state → IDLE.
  - In SHIFTING, the scan is complete and state → IDLE. The scan is accepted if the length check passes (see Configuration).
  - Accepted with upd_valid=0, or with upd_valid=1 & upd_ready=1 on the same edge: upd_data ← sr and upd_valid ← 1.
  - Accepted with upd_valid=1 & upd_ready=0: data is dropped, upd_data is held, and overrun ← 1.
  - Rejected by the length check: len_err ← 1 and upd_* are unchanged.
- Handshake: the transfer occurs on the edge where upd_valid & upd_ready. upd_valid falls after that edge unless a new accepted scan completes on the same edge.
- Priority when strobes overlap on one edge: capture > shift > update. The BSCANE2 TAP never overlaps them legally; this rule only defines the behaviour.
- If capture clears a flag on the same edge that an error would set it, the set wins.

## Timing
- Reset values:
  - state=IDLE, sr=0, cnt=0
  - upd_data=0, upd_valid=0
  - overrun=0, len_err=0, tdo=0
- Capture → first shifted-out bit: sr[0] is on tdo immediately after the capture edge. Bit k appears after k shift edges.
- Update edge → upd_valid high after that same edge (1-cycle registered latency).
- Reset asserted mid-scan aborts the scan with no update and clears any pending upd_valid.
- The system side must synchronise upd_valid/upd_ready itself. TCK is free-running only while the TAP is active.

## Configuration
- BSCAN_DR_LENCHECK_EN:
  - Defined: a scan is accepted only if cnt == DR_WIDTH at update. Any other non-zero count sets len_err, including counts saturated at DR_WIDTH+1.
  - Undefined: any scan with cnt ≥ 1 is accepted and upd_data ← sr as shifted; len_err is tied 0 and reads back as 0 at capture.

## Test plan
- Reset, then sel=1, capture with cap_data=0xA5A5A5A4, then shift 32 bits of tdi = 0x12345678 LSB-first. Required: tdo emits 0xA5A5A5A4 LSB-first; after update, upd_valid=1 next cycle and upd_data=0x12345678.
- Hold upd_ready=0, then complete a second 32-bit scan of 0xDEADBEEF. Required: upd_data stays 0x12345678 and overrun=1. The next capture shifts out bit0=1, then overrun=0.
- upd_valid=1; assert upd_ready on the same edge as the update of scan 0xCAFEF00D. Required: upd_data=0xCAFEF00D, upd_valid stays 1, overrun=0.
- With BSCAN_DR_LENCHECK_EN, shift 31 bits then update. Required: upd_valid unchanged and len_err=1. Repeat with 40 bits → len_err=1. Without the macro, a 31-bit scan is accepted.
- Deassert sel after 10 shifts, then pulse update with sel=0. Required: no update and state returns to IDLE. Capture→update with 0 shifts → no update and no error.
- Assert reset while in SHIFTING with upd_valid=1. Required: all outputs 0 immediately; the following update produces no transfer.
